mem_arbiter: RTL and testbench

- Shares the single unified instruction/data memory of the multicycle core between two requesters: the CPU memory port (IorD path) and a DMA/program-loader port.
- Accepts one transaction at a time and drives the memory interface from latched request fields.
- Returns read data and a one-cycle ack to the winning requester.
- Sits between the core datapath, the loader and the memory macro. The main control FSM stalls on cpu_ack.

---
 rtl/mem_arb_pkg.sv | 14 +
 rtl/mem_arb_pick.sv | 26 ++
 rtl/mem_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the CPU/DMA memory arbiter: FSM state encoding and owner constants.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select between CPU and DMA requests; no state, no backpressure.
// MEM_ARB_RR_EN: on a tie the port that did not win last time is chosen, else CPU always wins.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic cpu_req,
  input  logic dma_req,
  input  logic last_owner,
  output logic grant_dma
);

`ifdef MEM_ARB_RR_EN
  always_comb begin
    grant_dma = dma_req;
    if (cpu_req && dma_req) begin
      grant_dma = (last_owner == OWN_CPU);
    end
  end
`else
  // Fixed priority has no use for history; the tie below keeps the port list uniform.
  logic unused_last_owner;
  assign unused_last_owner = last_owner;
  assign grant_dma = dma_req && !cpu_req;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory between CPU and DMA ports, one transaction at a time; ack MEM_LAT+2 cycles after grant.
// Requesters hold req until ack; a losing port waits for the next IDLE. MEM_ARB_RR_EN enables round-robin ties.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1,
  parameter int CW      = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_ack,
  output logic [DW-1:0] dma_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          owner
);

  state_e        state_q;
  logic [CW-1:0] lat_q;
  logic [AW-1:0] a_q;
  logic          we_q;
  logic [DW-1:0] wd_q;
  logic [DW-1:0] rdata_q;
  logic          owner_q;
  logic          mem_en_q;
  logic          cpu_ack_q;
  logic          dma_ack_q;
  logic          busy_q;
  logic          last_owner;
  logic          grant_dma;

`ifdef MEM_ARB_RR_EN
  // Reset to DMA so the CPU wins the first tie.
  logic last_owner_q;
  assign last_owner = last_owner_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_owner_q <= OWN_DMA;
    end else if (state_q == IDLE && (cpu_req || dma_req)) begin
      last_owner_q <= grant_dma;
    end
  end
`else
  assign last_owner = OWN_DMA;
`endif

  mem_arb_pick u_pick (
    .cpu_req    (cpu_req),
    .dma_req    (dma_req),
    .last_owner (last_owner),
    .grant_dma  (grant_dma)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      lat_q     <= '0;
      a_q       <= '0;
      we_q      <= 1'b0;
      wd_q      <= '0;
      rdata_q   <= '0;
      owner_q   <= OWN_CPU;
      mem_en_q  <= 1'b0;
      cpu_ack_q <= 1'b0;
      dma_ack_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      mem_en_q  <= 1'b0;
      cpu_ack_q <= 1'b0;
      dma_ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cpu_req || dma_req) begin
            a_q      <= grant_dma ? dma_addr  : cpu_addr;
            we_q     <= grant_dma ? dma_we    : cpu_we;
            wd_q     <= grant_dma ? dma_wdata : cpu_wdata;
            owner_q  <= grant_dma;
            mem_en_q <= 1'b1;
            busy_q   <= 1'b1;
            state_q  <= ACCESS;
          end
        end
        ACCESS: begin
          lat_q   <= CW'(MEM_LAT - 1);
          state_q <= WAIT;
        end
        WAIT: begin
          // Acks are registered here so they are high for exactly the DONE cycle.
          if (lat_q == '0) begin
            rdata_q   <= mem_rdata;
            cpu_ack_q <= (owner_q == OWN_CPU);
            dma_ack_q <= (owner_q == OWN_DMA);
            state_q   <= DONE;
          end else begin
            lat_q <= lat_q - CW'(1);
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = we_q;
  assign mem_addr  = a_q;
  assign mem_wdata = wd_q;
  assign cpu_ack   = cpu_ack_q;
  assign dma_ack   = dma_ack_q;
  assign cpu_rdata = rdata_q;
  assign dma_rdata = rdata_q;
  assign busy      = busy_q;
  assign owner     = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: instance 0 runs MEM_LAT=1, instance 1 runs MEM_LAT=3, each with its own memory model.
// Honours MEM_ARB_RR_EN for the expected tie-break order.
module tb_mem_arbiter;

  localparam int L0 = 1;
  localparam int L1 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst_n;
  logic [1:0]       cpu_req, cpu_we, dma_req, dma_we;
  logic [1:0][31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic [1:0]       cpu_ack, dma_ack, mem_en, mem_we, busy, owner;
  logic [1:0][31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;

  function automatic logic [31:0] mval(input logic [31:0] a);
    return (a == 32'h40) ? 32'hDEADBEEF : ((a * 32'h9E3779B1) ^ 32'h5A5AC3C3);
  endfunction

  for (genvar k = 0; k < 2; k++) begin : g_dut
    localparam int LAT = (k == 0) ? L0 : L1;
    logic [31:0] pipe [3];

    mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(LAT), .CW(4)) u_dut (
      .clk(clk), .reset_n(rst_n[k]),
      .cpu_req(cpu_req[k]), .cpu_we(cpu_we[k]), .cpu_addr(cpu_addr[k]), .cpu_wdata(cpu_wdata[k]),
      .cpu_ack(cpu_ack[k]), .cpu_rdata(cpu_rdata[k]),
      .dma_req(dma_req[k]), .dma_we(dma_we[k]), .dma_addr(dma_addr[k]), .dma_wdata(dma_wdata[k]),
      .dma_ack(dma_ack[k]), .dma_rdata(dma_rdata[k]),
      .mem_en(mem_en[k]), .mem_we(mem_we[k]), .mem_addr(mem_addr[k]), .mem_wdata(mem_wdata[k]),
      .mem_rdata(mem_rdata[k]), .busy(busy[k]), .owner(owner[k])
    );

    // Read data shows up LAT cycles after the strobe cycle; random junk at every other time.
    always @(posedge clk) begin
      pipe[0] <= (mem_en[k] && !mem_we[k]) ? mval(mem_addr[k]) : $urandom;
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
    end
    assign mem_rdata[k] = pipe[LAT-1];
  end

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [159:0] obs(input int k);
    return {mem_en[k], mem_we[k], cpu_ack[k], dma_ack[k], busy[k], owner[k],
            mem_addr[k], mem_wdata[k], cpu_rdata[k], dma_rdata[k]};
  endfunction

  task automatic new_txn(input int k, input bit is_dma);
    if (is_dma) begin
      dma_req[k] = 1'b1; dma_we[k] = ($urandom_range(1) == 1);
      dma_addr[k] = $urandom; dma_wdata[k] = $urandom;
    end else begin
      cpu_req[k] = 1'b1; cpu_we[k] = ($urandom_range(1) == 1);
      cpu_addr[k] = $urandom; cpu_wdata[k] = $urandom;
    end
  endtask

  typedef struct {
    logic cr, cw; logic [31:0] ca, cd;
    logic dr, dw; logic [31:0] da, dd;
    logic en, we; logic [31:0] ad, wd;
    logic cack, dack, own, bsy;
    logic [31:0] rd;
  } vec_t;

  vec_t        tbl [9];
  logic [3:0]  seq, exp_seq;
  int          nack, lat;
  int          g [2], free_at [2];
  logic        t_own [2], t_we [2], shown [2], last [2], cgr [2], dgr [2];
  logic [31:0] t_ad [2], t_wd [2];
  logic        ea, wdma;

  initial begin
    // CPU read of 0x40, then DMA write of 0x1234 to 0x100 (MEM_LAT=1).
    tbl[0] = '{1'b1,1'b0,32'h40,32'h0, 1'b0,1'b0,32'h0,32'h0,    1'b0,1'b0,32'h0,32'h0,      1'b0,1'b0,1'b0,1'b0, 32'h0};
    tbl[1] = '{1'b1,1'b0,32'h40,32'h0, 1'b0,1'b0,32'h0,32'h0,    1'b1,1'b0,32'h40,32'h0,     1'b0,1'b0,1'b0,1'b1, 32'h0};
    tbl[2] = '{1'b1,1'b0,32'h40,32'h0, 1'b0,1'b0,32'h0,32'h0,    1'b0,1'b0,32'h40,32'h0,     1'b0,1'b0,1'b0,1'b1, 32'h0};
    tbl[3] = '{1'b1,1'b0,32'h40,32'h0, 1'b0,1'b0,32'h0,32'h0,    1'b0,1'b0,32'h40,32'h0,     1'b1,1'b0,1'b0,1'b1, 32'hDEADBEEF};
    tbl[4] = '{1'b0,1'b0,32'h0,32'h0,  1'b1,1'b1,32'h100,32'h1234, 1'b0,1'b0,32'h40,32'h0,   1'b0,1'b0,1'b0,1'b0, 32'h0};
    tbl[5] = '{1'b0,1'b0,32'h0,32'h0,  1'b1,1'b1,32'h100,32'h1234, 1'b1,1'b1,32'h100,32'h1234, 1'b0,1'b0,1'b1,1'b1, 32'h0};
    tbl[6] = '{1'b0,1'b0,32'h0,32'h0,  1'b1,1'b1,32'h100,32'h1234, 1'b0,1'b1,32'h100,32'h1234, 1'b0,1'b0,1'b1,1'b1, 32'h0};
    tbl[7] = '{1'b0,1'b0,32'h0,32'h0,  1'b1,1'b1,32'h100,32'h1234, 1'b0,1'b1,32'h100,32'h1234, 1'b0,1'b1,1'b1,1'b1, 32'h0};
    tbl[8] = '{1'b0,1'b0,32'h0,32'h0,  1'b0,1'b0,32'h0,32'h0,    1'b0,1'b1,32'h100,32'h1234, 1'b0,1'b0,1'b1,1'b0, 32'h0};

    rst_n = 2'b00;
    cpu_req = '0; cpu_we = '0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = '0; dma_we = '0; dma_addr = '0; dma_wdata = '0;
    repeat (2) @(negedge clk);
    chk("reset0", obs(0), '0);
    chk("reset1", obs(1), '0);
    rst_n = 2'b11;

    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      cpu_req[0] = tbl[i].cr; cpu_we[0] = tbl[i].cw; cpu_addr[0] = tbl[i].ca; cpu_wdata[0] = tbl[i].cd;
      dma_req[0] = tbl[i].dr; dma_we[0] = tbl[i].dw; dma_addr[0] = tbl[i].da; dma_wdata[0] = tbl[i].dd;
      chk("tbl", {mem_en[0], mem_we[0], mem_addr[0], mem_wdata[0], cpu_ack[0], dma_ack[0], owner[0], busy[0]},
                 {tbl[i].en, tbl[i].we, tbl[i].ad, tbl[i].wd, tbl[i].cack, tbl[i].dack, tbl[i].own, tbl[i].bsy});
      if ((tbl[i].cack || tbl[i].dack) && !tbl[i].we)
        chk("tbl_rdata", tbl[i].cack ? cpu_rdata[0] : dma_rdata[0], tbl[i].rd);
    end

    // Both ports request back to back; record who is acked for four transactions.
`ifdef MEM_ARB_RR_EN
    exp_seq = 4'b1010;
`else
    exp_seq = 4'b0000;
`endif
    seq = 'x;
    nack = 0;
    @(negedge clk);
    cpu_req[0] = 1'b1; cpu_we[0] = 1'b0; cpu_addr[0] = 32'h10;
    dma_req[0] = 1'b1; dma_we[0] = 1'b0; dma_addr[0] = 32'h20;
    for (int c = 0; c < 40 && nack < 4; c++) begin
      @(negedge clk);
      if (cpu_ack[0] || dma_ack[0]) begin
        seq[nack] = dma_ack[0];
        nack++;
        if (nack == 4) begin
          cpu_req[0] = 1'b0; dma_req[0] = 1'b0;
        end
      end
    end
    chk("tie_count", nack, 4);
    for (int i = 0; i < 4; i++) chk("tie_order", seq[i], exp_seq[i]);

    // Address change after the sample is ignored; a DMA request raised mid-flight waits for IDLE.
    repeat (2) @(negedge clk);
    cpu_req[0] = 1'b1; cpu_we[0] = 1'b0; cpu_addr[0] = 32'h40;
    @(negedge clk);
    cpu_addr[0] = 32'h80; dma_req[0] = 1'b1; dma_we[0] = 1'b0; dma_addr[0] = 32'h200;
    chk("hold_access", {mem_en[0], mem_addr[0]}, {1'b1, 32'h40});
    @(negedge clk);
    chk("hold_wait", {mem_en[0], mem_addr[0]}, {1'b0, 32'h40});
    @(negedge clk);
    chk("hold_ack", {cpu_ack[0], dma_ack[0], cpu_rdata[0]}, {1'b1, 1'b0, 32'hDEADBEEF});
    cpu_req[0] = 1'b0;
    @(negedge clk);
    chk("late_idle", {busy[0], mem_en[0]}, 2'b00);
    @(negedge clk);
    chk("late_grant", {mem_en[0], owner[0], mem_addr[0]}, {1'b1, 1'b1, 32'h200});
    repeat (2) @(negedge clk);
    chk("late_ack", {dma_ack[0], cpu_ack[0], dma_rdata[0]}, {1'b1, 1'b0, mval(32'h200)});
    dma_req[0] = 1'b0;

    // MEM_LAT=3 read: ack on cycle 5 with the data that arrives 3 cycles after the strobe.
    cpu_req[1] = 1'b1; cpu_we[1] = 1'b0; cpu_addr[1] = 32'h40;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      chk("lat3_ctl", {mem_en[1], cpu_ack[1], dma_ack[1]}, {c == 1, c == 5, 1'b0});
      if (c == 5) begin
        chk("lat3_rdata", cpu_rdata[1], 32'hDEADBEEF);
        cpu_req[1] = 1'b0;
      end
    end

    // Reset during WAIT abandons the transaction; a DMA read afterwards completes normally.
    cpu_req[1] = 1'b1; cpu_addr[1] = 32'h44;
    repeat (2) @(negedge clk);
    rst_n[1] = 1'b0; cpu_req[1] = 1'b0;
    #1 chk("rst_async", obs(1), '0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 1) rst_n[1] = 1'b1;
      chk("rst_noack", {cpu_ack[1], dma_ack[1], mem_en[1], busy[1]}, 4'b0);
    end
    dma_req[1] = 1'b1; dma_we[1] = 1'b0; dma_addr[1] = 32'h44;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      chk("rst_dma", {mem_en[1], dma_ack[1], cpu_ack[1]}, {c == 1, c == 5, 1'b0});
      if (c == 5) begin
        chk("rst_dma_rdata", dma_rdata[1], mval(32'h44));
        dma_req[1] = 1'b0;
      end
    end

    // Random traffic on both instances against a transaction-level model.
    for (int k = 0; k < 2; k++) begin
      g[k] = -100; free_at[k] = 0; shown[k] = 1'b1; last[k] = 1'b1;
      cgr[k] = 1'b0; dgr[k] = 1'b0; t_own[k] = 1'b0; t_we[k] = 1'b0; t_ad[k] = '0; t_wd[k] = '0;
    end
    for (int c = 0; c < 700; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        lat = (k == 0) ? L0 : L1;
        ea = (c == g[k] + lat + 2);
        if (c == g[k] + 1) shown[k] = t_own[k];
        chk("rnd_ctl", {mem_en[k], busy[k], cpu_ack[k], dma_ack[k], owner[k]},
            {c == g[k] + 1, (c > g[k]) && (c <= g[k] + lat + 2), ea && !t_own[k], ea && t_own[k], shown[k]});
        if (c > g[k] && c <= g[k] + lat + 1)
          chk("rnd_bus", {mem_we[k], mem_addr[k], mem_wdata[k]}, {t_we[k], t_ad[k], t_wd[k]});
        if (ea && !t_we[k])
          chk("rnd_rdata", t_own[k] ? dma_rdata[k] : cpu_rdata[k], mval(t_ad[k]));

        if (ea) begin
          if (t_own[k]) begin
            dgr[k] = 1'b0;
            if ($urandom_range(1) == 0) dma_req[k] = 1'b0; else new_txn(k, 1'b1);
          end else begin
            cgr[k] = 1'b0;
            if ($urandom_range(1) == 0) cpu_req[k] = 1'b0; else new_txn(k, 1'b0);
          end
        end
        if (!cpu_req[k] && $urandom_range(3) == 0) new_txn(k, 1'b0);
        if (!dma_req[k] && $urandom_range(3) == 0) new_txn(k, 1'b1);
        if (cgr[k]) new_txn(k, 1'b0);
        if (dgr[k]) new_txn(k, 1'b1);

        if (c >= free_at[k] && (cpu_req[k] || dma_req[k])) begin
`ifdef MEM_ARB_RR_EN
          wdma = (cpu_req[k] && dma_req[k]) ? !last[k] : dma_req[k];
          last[k] = wdma;
`else
          wdma = !cpu_req[k];
`endif
          g[k] = c;
          free_at[k] = c + lat + 3;
          t_own[k] = wdma;
          t_we[k]  = wdma ? dma_we[k]    : cpu_we[k];
          t_ad[k]  = wdma ? dma_addr[k]  : cpu_addr[k];
          t_wd[k]  = wdma ? dma_wdata[k] : cpu_wdata[k];
          if (wdma) dgr[k] = 1'b1; else cgr[k] = 1'b1;
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
